// File: rtl/bsc_pkg.sv
// Shared definitions for the bank strobe controller: FSM state encoding,
// default control-word bit positions and the strobe-width counter sizing.
package bsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STRB = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } bsc_state_e;

    localparam int DEF_STRB_EN_BIT  = 3;
    localparam int DEF_STRB_SEL_BIT = 4;
    localparam int DEF_INC_BIT      = 6;

    // Counter only has to hold STRB_CYCLES-1; a single bit covers widths 1 and 2.
    function automatic int strb_cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/bsc_strb_timer.sv
// Loadable down-counter timing the strobe low width; expired goes high
// once STRB_CYCLES clocks have elapsed since the last load.
module bsc_strb_timer #(
    parameter int STRB_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);
    import bsc_pkg::*;

    localparam int CW = strb_cnt_width(STRB_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(STRB_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/bank_strobe_ctlr.sv
// Bank strobe controller: latches a control word on a qualified LoadN fall and
// issues one or a burst of timed active-low strobes with busy/done/overrun status.
module bank_strobe_ctlr
    import bsc_pkg::*;
#(
    parameter int DWIDTH       = 8,
    parameter int BSWIDTH      = 3,
    parameter int NSTRB        = 2,
    parameter int STRB_CYCLES  = 1,
    parameter int BURST_WIDTH  = 4,
    parameter int STRB_EN_BIT  = DEF_STRB_EN_BIT,
    parameter int STRB_SEL_BIT = DEF_STRB_SEL_BIT,
    parameter int INC_BIT      = DEF_INC_BIT
) (
    input  logic                   BSC_PClk,
    input  logic                   BSC_ResetN,
    input  logic [DWIDTH-1:0]      BSC_Data_Bus,
    input  logic                   BSC_LoadN,
    input  logic [BURST_WIDTH-1:0] BSC_BurstLen,
    output logic [NSTRB-1:0]       BSC_StrbN,
    output logic [BSWIDTH-1:0]     BSC_BSel,
    output logic                   BSC_Addr_Inc,
    output logic                   BSC_Busy,
    output logic                   BSC_Done,
    output logic                   BSC_Ovr,
    output logic [DWIDTH-1:0]      BSC_Status
);

    bsc_state_e             state, state_nx;
    logic [DWIDTH-1:0]      status, status_nx;
    logic [BURST_WIDTH-1:0] burst_cnt, burst_nx;
    logic [NSTRB-1:0]       strb_nx, sel_mask;
    logic                   prev_load_n;
    logic                   ovr, ovr_nx;
    logic                   fall, accept;
    logic                   timer_load, timer_expired;
    int                     strb_idx;

    assign fall   = prev_load_n & ~BSC_LoadN;
    assign accept = fall && (state == IDLE);

    bsc_strb_timer #(
        .STRB_CYCLES (STRB_CYCLES)
    ) u_timer (
        .clk     (BSC_PClk),
        .rst_n   (BSC_ResetN),
        .load    (timer_load),
        .expired (timer_expired)
    );

    // Strobe select and output values are derived from the post-edge status so
    // the first strobe can go low on the very edge that accepts the word.
    always_comb begin
        state_nx   = state;
        status_nx  = status;
        burst_nx   = burst_cnt;
        ovr_nx     = ovr;
        timer_load = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    status_nx  = BSC_Data_Bus;
                    burst_nx   = BSC_BurstLen;
                    state_nx   = BSC_Data_Bus[STRB_EN_BIT] ? STRB : DONE;
                    timer_load = BSC_Data_Bus[STRB_EN_BIT];
                end
            end
            STRB: begin
                if (timer_expired) state_nx = GAP;
            end
            GAP: begin
                if (status[INC_BIT] && (burst_cnt != '0)) begin
                    burst_nx   = burst_cnt - 1'b1;
                    state_nx   = STRB;
                    timer_load = 1'b1;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (accept)    ovr_nx = 1'b0;
        else if (fall) ovr_nx = 1'b1;

        strb_idx = ((NSTRB > 1) && status_nx[STRB_SEL_BIT]) ? 1 : 0;
        sel_mask = '0;
        for (int i = 0; i < NSTRB; i++) begin
            sel_mask[i] = (i == strb_idx);
        end
        strb_nx = (state_nx == STRB) ? ~sel_mask : '1;
    end

    always_ff @(negedge BSC_PClk or negedge BSC_ResetN) begin
        if (!BSC_ResetN) begin
            state       <= IDLE;
            status      <= '0;
            burst_cnt   <= '0;
            prev_load_n <= 1'b1;
            ovr         <= 1'b0;
            BSC_StrbN   <= '1;
            BSC_Busy    <= 1'b0;
            BSC_Done    <= 1'b0;
        end else begin
            state       <= state_nx;
            status      <= status_nx;
            burst_cnt   <= burst_nx;
            prev_load_n <= BSC_LoadN;
            ovr         <= ovr_nx;
            BSC_StrbN   <= strb_nx;
            BSC_Busy    <= (state_nx != IDLE);
            BSC_Done    <= (state_nx == DONE);
        end
    end

    assign BSC_Status   = status;
    assign BSC_BSel     = status[BSWIDTH-1:0];
    assign BSC_Addr_Inc = status[INC_BIT];
    assign BSC_Ovr      = ovr;

endmodule

// File: tb/tb_bank_strobe_ctlr.sv
// Self-checking bench: per-cycle expected strobe/busy/done traces are queued at
// load time and popped against the DUT outputs each clock.
module tb_bank_strobe_ctlr;

    typedef struct packed {
        logic [1:0] strb_n;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_a, data_b;
    logic       load_n_a, load_n_b;
    logic [3:0] burst_a, burst_b;
    logic [1:0] strb_n_a, strb_n_b;
    logic [2:0] bsel_a, bsel_b;
    logic       inc_a, inc_b, busy_a, busy_b, done_a, done_b, ovr_a, ovr_b;
    logic [7:0] status_a, status_b;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bank_strobe_ctlr dut_a (
        .BSC_PClk (clk), .BSC_ResetN (rst_n), .BSC_Data_Bus (data_a),
        .BSC_LoadN (load_n_a), .BSC_BurstLen (burst_a), .BSC_StrbN (strb_n_a),
        .BSC_BSel (bsel_a), .BSC_Addr_Inc (inc_a), .BSC_Busy (busy_a),
        .BSC_Done (done_a), .BSC_Ovr (ovr_a), .BSC_Status (status_a)
    );

    bank_strobe_ctlr #(.STRB_CYCLES(2)) dut_b (
        .BSC_PClk (clk), .BSC_ResetN (rst_n), .BSC_Data_Bus (data_b),
        .BSC_LoadN (load_n_b), .BSC_BurstLen (burst_b), .BSC_StrbN (strb_n_b),
        .BSC_BSel (bsel_b), .BSC_Addr_Inc (inc_b), .BSC_Busy (busy_b),
        .BSC_Done (done_b), .BSC_Ovr (ovr_b), .BSC_Status (status_b)
    );

    // n strobes of 'width' low clocks each followed by one high clock, then a
    // single done clock, then one idle clock to prove nothing follows.
    function automatic void push_trace(input int n, input int width, input int line);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < width; j++) begin
                e.strb_n = (line != 0) ? 2'b01 : 2'b10;
                e.busy = 1'b1; e.done = 1'b0;
                exp_q.push_back(e);
            end
            e.strb_n = 2'b11; e.busy = 1'b1; e.done = 1'b0;
            exp_q.push_back(e);
        end
        e.strb_n = 2'b11; e.busy = 1'b1; e.done = 1'b1;
        exp_q.push_back(e);
        e.strb_n = 2'b11; e.busy = 1'b0; e.done = 1'b0;
        exp_q.push_back(e);
    endfunction

    task automatic test_reset();
        #12;
        checks++;
        if ({strb_n_a, busy_a, done_a, ovr_a, status_a} !== {2'b11, 3'b000, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reset_a got %b want %b", {strb_n_a, busy_a, done_a, ovr_a, status_a}, {2'b11, 11'b0});
        end
        checks++;
        if ({strb_n_b, busy_b, done_b, ovr_b, status_b} !== {2'b11, 3'b000, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reset_b got %b want %b", {strb_n_b, busy_b, done_b, ovr_b, status_b}, {2'b11, 11'b0});
        end
        @(posedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_strobe();
        exp_t e, obs;
        @(posedge clk);
        data_a = 8'h0D; burst_a = 4'd7; load_n_a = 1'b0;
        push_trace(1, 1, 0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(posedge clk);
            e = exp_q.pop_front();
            obs = {strb_n_a, busy_a, done_a};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL single c%0d strb/busy/done got %b want %b", c, obs, e);
            end
            if (c == 0) begin
                checks++;
                if ({bsel_a, inc_a, status_a} !== {3'd5, 1'b0, 8'h0D}) begin
                    errors++;
                    $display("[TB] FAIL single_status got %b want %b", {bsel_a, inc_a, status_a}, {3'd5, 1'b0, 8'h0D});
                end
                load_n_a = 1'b1; data_a = 8'hFF; burst_a = 4'd0;
            end
        end
    endtask

    task automatic test_burst_width2();
        exp_t e, obs;
        @(posedge clk);
        data_b = 8'h58; burst_b = 4'd3; load_n_b = 1'b0;
        push_trace(4, 2, 1);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(posedge clk);
            e = exp_q.pop_front();
            obs = {strb_n_b, busy_b, done_b};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL burst_b c%0d strb/busy/done got %b want %b", c, obs, e);
            end
            if (c == 0) begin
                checks++;
                if ({bsel_b, inc_b, status_b} !== {3'd0, 1'b1, 8'h58}) begin
                    errors++;
                    $display("[TB] FAIL burst_b_status got %b want %b", {bsel_b, inc_b, status_b}, {3'd0, 1'b1, 8'h58});
                end
                load_n_b = 1'b1; data_b = 8'h00; burst_b = 4'd0;
            end
        end
    endtask

    task automatic test_disabled();
        exp_t e, obs;
        @(posedge clk);
        data_a = 8'h02; burst_a = 4'd5; load_n_a = 1'b0;
        push_trace(0, 1, 0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(posedge clk);
            e = exp_q.pop_front();
            obs = {strb_n_a, busy_a, done_a};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL disabled c%0d strb/busy/done got %b want %b", c, obs, e);
            end
            if (c == 0) begin
                checks++;
                if ({bsel_a, status_a} !== {3'd2, 8'h02}) begin
                    errors++;
                    $display("[TB] FAIL disabled_status got %b want %b", {bsel_a, status_a}, {3'd2, 8'h02});
                end
                load_n_a = 1'b1;
            end
        end
    endtask

    task automatic test_burst_bounds();
        exp_t e, obs;
        int lens[2] = '{0, 15};
        for (int t = 0; t < 2; t++) begin
            @(posedge clk);
            data_a = 8'h48; burst_a = 4'(lens[t]); load_n_a = 1'b0;
            push_trace(1 + lens[t], 1, 0);
            for (int c = 0; exp_q.size() > 0; c++) begin
                @(posedge clk);
                e = exp_q.pop_front();
                obs = {strb_n_a, busy_a, done_a};
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("[TB] FAIL bound_len%0d c%0d got %b want %b", lens[t], c, obs, e);
                end
                if (c == 0) load_n_a = 1'b1;
            end
        end
    endtask

    // Second LoadN fall lands on a STRB clock (burst) and then on the DONE clock.
    task automatic test_overrun();
        exp_t e, obs;
        logic [7:0] words[2] = '{8'h48, 8'h0D};
        int ns[2] = '{4, 1};
        for (int t = 0; t < 2; t++) begin
            @(posedge clk);
            data_a = words[t]; burst_a = 4'd3; load_n_a = 1'b0;
            push_trace(ns[t], 1, 0);
            for (int c = 0; exp_q.size() > 0; c++) begin
                @(posedge clk);
                e = exp_q.pop_front();
                obs = {strb_n_a, busy_a, done_a};
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("[TB] FAIL overrun%0d c%0d got %b want %b", t, c, obs, e);
                end
                if (c == 0) begin
                    checks++;
                    if (ovr_a !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL ovr_clear%0d got %b want 0", t, ovr_a);
                    end
                    load_n_a = 1'b1; data_a = 8'hA5;
                end
                if (c == 2) load_n_a = 1'b0;
                if (c == 3) load_n_a = 1'b1;
            end
            @(posedge clk);
            checks++;
            if ({ovr_a, busy_a, status_a} !== {1'b1, 1'b0, words[t]}) begin
                errors++;
                $display("[TB] FAIL overrun_flag%0d got %b want %b", t, {ovr_a, busy_a, status_a}, {1'b1, 1'b0, words[t]});
            end
        end
    endtask

    task automatic test_level_held();
        exp_t e, obs;
        @(posedge clk);
        data_a = 8'h0D; burst_a = 4'd0; load_n_a = 1'b0;
        push_trace(1, 1, 0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = {2'b11, 1'b0, 1'b0};
            end
            obs = {strb_n_a, busy_a, done_a};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL held c%0d got %b want %b", c, obs, e);
            end
        end
        load_n_a = 1'b1;
        @(posedge clk);
        load_n_a = 1'b0;
        push_trace(1, 1, 0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(posedge clk);
            e = exp_q.pop_front();
            obs = {strb_n_a, busy_a, done_a};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL reassert c%0d got %b want %b", c, obs, e);
            end
            if (c == 0) load_n_a = 1'b1;
        end
    endtask

    task automatic test_reset_mid_burst();
        exp_t e, obs;
        @(posedge clk);
        data_a = 8'h48; burst_a = 4'd3; load_n_a = 1'b0;
        push_trace(4, 1, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            e = exp_q.pop_front();
            obs = {strb_n_a, busy_a, done_a};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL midburst c%0d got %b want %b", c, obs, e);
            end
            if (c == 0) load_n_a = 1'b1;
            if (c == 1) load_n_a = 1'b0;
        end
        checks++;
        if (ovr_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midburst_ovr got %b want 1", ovr_a);
        end
        exp_q.delete();
        load_n_a = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({strb_n_a, busy_a, done_a, ovr_a, status_a} !== {2'b11, 3'b000, 8'h00}) begin
            errors++;
            $display("[TB] FAIL async_reset got %b want %b", {strb_n_a, busy_a, done_a, ovr_a, status_a}, {2'b11, 11'b0});
        end
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            checks++;
            if ({strb_n_a, busy_a, done_a} !== {2'b11, 2'b00}) begin
                errors++;
                $display("[TB] FAIL post_reset_idle got %b want 1100", {strb_n_a, busy_a, done_a});
            end
        end
        @(posedge clk);
        data_a = 8'h0D; burst_a = 4'd0; load_n_a = 1'b0;
        push_trace(1, 1, 0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(posedge clk);
            e = exp_q.pop_front();
            obs = {strb_n_a, busy_a, done_a};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL after_reset c%0d got %b want %b", c, obs, e);
            end
            if (c == 0) load_n_a = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        data_a = 8'h00; load_n_a = 1'b1; burst_a = 4'd0;
        data_b = 8'h00; load_n_b = 1'b1; burst_b = 4'd0;
        test_reset();
        test_single_strobe();
        test_burst_width2();
        test_disabled();
        test_burst_bounds();
        test_overrun();
        test_level_held();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
